// File: rtl/parse_pkg.sv
// Shared definitions for the parse stage: slot layout, constants
// and the slot field decoder.
package parse_pkg;

    localparam int BUNDLE_W = 60;
    localparam int SLOT_W   = 30;

    localparam int FMT_BIT  = 29;
    localparam int BR_BIT   = 28;
    localparam int OP_HI    = 27;
    localparam int OP_LO    = 21;
    localparam int PRIM_HI  = 20;
    localparam int PRIM_LO  = 16;
    localparam int SEC_HI   = 15;
    localparam int SEC_LO   = 11;
    localparam int IMM_HI   = 15;
    localparam int IMM_LO   = 0;

    localparam logic [SLOT_W-1:0] NOP_SLOT = '0;

    localparam logic FORMAT_REG_IMM = 1'b1;
    localparam logic FORMAT_REG_REG = 1'b0;

    typedef enum logic {
        SLOT0 = 1'b0,
        SLOT1 = 1'b1
    } slot_state_e;

    typedef struct packed {
        logic       fmt;
        logic       branch;
        logic [6:0] opcode;
        logic [4:0] prim;
        logic [4:0] sec;
        logic [15:0] imm;
    } dec_t;

    function automatic dec_t decode_slot(
        input logic [SLOT_W-1:0] s
    );
        dec_t d;
        d.fmt    = s[FMT_BIT];
        d.branch = s[BR_BIT];
        d.opcode = s[OP_HI:OP_LO];
        d.prim   = s[PRIM_HI:PRIM_LO];
        if (d.fmt == FORMAT_REG_IMM) begin
            d.sec = '0;
            d.imm = s[IMM_HI:IMM_LO];
        end else begin
            d.sec = s[SEC_HI:SEC_LO];
            d.imm = '0;
        end
        return d;
    endfunction

endpackage

// File: rtl/parse_unit_if.sv
// Fetch-side and issue-side signals of the parse stage.
// slave is the parse unit's view, master the surrounding pipeline's.
interface parse_unit_if #(
    parameter int PC_W = 16
);

    logic            flush_i;
    logic            enable_i;
    logic [PC_W-1:0] pc_i;
    logic [59:0]     data_i;
    logic            stall_i;

    logic            stall_o;
    logic            overflow_o;
    logic            enable_o;
    logic [PC_W-1:0] pc_o;
    logic            slot_o;
    logic            format_o;
    logic            branch_o;
    logic [6:0]      opcode_o;
    logic [4:0]      primReg_o;
    logic [4:0]      secReg_o;
    logic [15:0]     imm_o;

    modport slave (
        input  flush_i,
        input  enable_i,
        input  pc_i,
        input  data_i,
        input  stall_i,
        output stall_o,
        output overflow_o,
        output enable_o,
        output pc_o,
        output slot_o,
        output format_o,
        output branch_o,
        output opcode_o,
        output primReg_o,
        output secReg_o,
        output imm_o
    );

    modport master (
        output flush_i,
        output enable_i,
        output pc_i,
        output data_i,
        output stall_i,
        input  stall_o,
        input  overflow_o,
        input  enable_o,
        input  pc_o,
        input  slot_o,
        input  format_o,
        input  branch_o,
        input  opcode_o,
        input  primReg_o,
        input  secReg_o,
        input  imm_o
    );

endinterface

// File: rtl/bundle_fifo.sv
// Synchronous bundle FIFO; the caller decides when push/pop are legal.
// Occupancy is one bit wider than the pointers so full is distinct.
module bundle_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 76,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign rdata = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clock_i) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/parse_unit.sv
// Parse stage: buffers fetch bundles, splits them into two slots,
// skips NOP slots and issues one decoded instruction per cycle.
module parse_unit
    import parse_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 16
) (
    input logic         clock_i,
    input logic         reset_i,
    parse_unit_if.slave bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int FW = PC_W + BUNDLE_W;

    logic [FW-1:0]     head;
    logic              full;
    logic              empty;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_nx;

    slot_state_e       state;
    slot_state_e       state_nx;

    logic [SLOT_W-1:0] s0;
    logic [SLOT_W-1:0] s1;
    logic [PC_W-1:0]   head_pc;
    logic              active;
    logic              take0;
    logic              take1;
    logic              issue;
    logic              sel1;
    logic              pop;
    logic              accept;
    logic              drop;
    dec_t              dec;

    assign head_pc = head[BUNDLE_W +: PC_W];
    assign s0      = head[SLOT_W +: SLOT_W];
    assign s1      = head[0 +: SLOT_W];

    assign active = !bus.flush_i
                 && !bus.stall_i
                 && !empty;
    assign take0  = active
                 && (state == SLOT0)
                 && (s0 != NOP_SLOT);
    assign take1  = active && !take0;

    // A full FIFO still takes a bundle when the head pops this edge
    assign accept = bus.enable_i && !bus.flush_i
                 && (!full || pop);
    assign drop   = bus.enable_i && !bus.flush_i
                 && full && !pop;

    assign count_nx = count + CW'(accept)
                    - CW'(pop);

    bundle_fifo #(
        .DEPTH (DEPTH),
        .W     (FW)
    ) u_fifo (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .clear   (bus.flush_i),
        .push    (accept),
        .pop     (pop),
        .wdata   ({bus.pc_i, bus.data_i}),
        .rdata   (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state <= SLOT0;
        end else if (bus.flush_i) begin
            state <= SLOT0;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (1'b1)
            take0:   state_nx = SLOT1;
            take1:   state_nx = SLOT0;
            default: state_nx = state;
        endcase
    end

    always_comb begin
        issue = 1'b0;
        sel1  = 1'b0;
        pop   = 1'b0;
        unique case (1'b1)
            take0: issue = 1'b1;
            take1: begin
                issue = (s1 != NOP_SLOT);
                sel1  = 1'b1;
                pop   = 1'b1;
            end
            default: ;
        endcase
    end

    assign dec = decode_slot(sel1 ? s1 : s0);

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            bus.stall_o    <= 1'b0;
            bus.overflow_o <= 1'b0;
            bus.enable_o   <= 1'b0;
            bus.pc_o       <= '0;
            bus.slot_o     <= 1'b0;
            bus.format_o   <= 1'b0;
            bus.branch_o   <= 1'b0;
            bus.opcode_o   <= '0;
            bus.primReg_o  <= '0;
            bus.secReg_o   <= '0;
            bus.imm_o      <= '0;
        end else begin
            if (drop) begin
                bus.overflow_o <= 1'b1;
            end
            if (bus.flush_i) begin
                bus.enable_o <= 1'b0;
                bus.stall_o  <= 1'b0;
            end else begin
                bus.stall_o <=
                    (count_nx >= CW'(DEPTH - 1));
                if (!bus.stall_i) begin
                    bus.enable_o <= issue;
                    if (issue) begin
                        bus.pc_o      <= head_pc;
                        bus.slot_o    <= sel1;
                        bus.format_o  <= dec.fmt;
                        bus.branch_o  <= dec.branch;
                        bus.opcode_o  <= dec.opcode;
                        bus.primReg_o <= dec.prim;
                        bus.secReg_o  <= dec.sec;
                        bus.imm_o     <= dec.imm;
                    end
                end
            end
        end
    end

endmodule

// File: doc/parse_unit.md
Name: parse_unit

Overview:
- Stage 1 of the pipeline. Consumes the 60-bit dual-instruction bundles produced by the fetch stage (pc, data, enable).
- Buffers bundles in a small FIFO, splits each bundle into its two 30-bit instruction slots, drops NOP slots, and decodes the fields.
- Issues one decoded instruction per cycle to the dependency unit.
- Generates the stall back-pressure signal toward fetch.

Parameters:
- DEPTH, 4: bundle FIFO entries. Power of two, minimum 4.
- PC_W, 16: program counter width.

Ports:
- clock_i  in  1  system clock, all logic on rising edge
- reset_i  in  1  synchronous, active-low reset
- flush_i  in  1  pipeline flush (branch taken / flushBack)
- enable_i  in  1  fetch bundle valid
- pc_i  in  PC_W  pc of incoming bundle
- data_i  in  60  bundle: slot0 = [59:30], slot1 = [29:0]
- stall_i  in  1  dependency unit cannot accept; hold outputs
- stall_o  out  1  registered request to fetch to stop delivering
- overflow_o  out  1  sticky: a bundle arrived while FIFO full
- enable_o  out  1  decoded instruction valid
- pc_o  out  PC_W  pc of source bundle
- slot_o  out  1  0 = slot0, 1 = slot1
- format_o  out  1  1 = reg-imm, 0 = reg-reg
- branch_o  out  1  branch bit
- opcode_o  out  7  opcode
- primReg_o  out  5  primary register
- secReg_o  out  5  secondary register (reg-reg only, else 0)
- imm_o  out  16  immediate (reg-imm only, else 0)

Behaviour:
- Slot layout: [29] format, [28] branch, [27:21] opcode, [20:16] primary.
  - Reg-imm: [15:0] immediate.
  - Reg-reg: [15:11] secondary, [10:0] ignored.
- NOP slot: all 30 bits zero.
- Reset (reset_i == 0 at an edge):
  - FIFO emptied, slot index = 0.
  - All outputs = 0, including overflow_o.
- Flush (reset_i == 1, flush_i == 1):
  - FIFO emptied, slot index = 0, enable_o = 0, stall_o = 0.
  - enable_i in the same cycle is ignored.
  - overflow_o is kept.
  - Flush has priority over write, issue and stall_i.
- Write: enable_i == 1 and FIFO not full → push {pc_i, data_i}.
  - Full → bundle discarded and overflow_o set to 1 (sticky until reset).
- stall_o:
  - Registered; equals (occupancy after this edge >= DEPTH-1).
  - This leaves room for the one bundle fetch may deliver before it sees the stall.
- Issue: outputs are registered.
  - If stall_i == 1: all issue outputs hold and the FIFO does not pop. A write may still occur.
  - Otherwise, the head bundle is examined at the current slot index:
    - Index 0, slot0 non-NOP: issue slot0; index becomes 1.
    - Index 0, slot0 NOP: skip to slot1 within the same cycle.
    - Slot1 non-NOP: issue slot1; pop; index becomes 0.
    - Slot1 NOP: pop with no issue for that slot.
    - A bundle that is all NOP is popped in one cycle, with enable_o = 0 that cycle.
  - FIFO empty → enable_o = 0; other outputs hold their last value.
- Field decode:
  - format_o = 1 → secReg_o = 0, imm_o = [15:0].
  - format_o = 0 → secReg_o = [15:11], imm_o = 0.
- Latency:
  - A bundle written at edge N, into an empty FIFO with stall_i == 0, gives enable_o = 1 for slot0 after edge N+1, and for slot1 after edge N+2.
  - No write-to-issue bypass.
- Throughput: at most one instruction per cycle. Simultaneous push and pop on the same edge is legal at any occupancy except full-without-pop.
- Pointers wrap modulo DEPTH; occupancy is a DEPTH+1-valued counter.

Decomposition:
- Shared package parse_pkg holds:
  - Slot bit positions and widths.
  - Bundle width 60, slot width 30.
  - NOP_SLOT constant (30'b0).
  - FORMAT_REG_IMM / FORMAT_REG_REG constants.
- Natural sub-module: bundle_fifo.
  - Synchronous FIFO of {PC_W+60} bits, DEPTH entries.
  - Provides push/pop, full, empty and count outputs.
- parse_unit itself holds the slot-index FSM, NOP skip, decode and the stall/overflow logic.

Test Plan:
- Reset release, then one bundle at pc 1, data = {1_0_0001010_00001_0000000000000101, 1_0_0001010_00010_0000000000001010}:
  - Cycle +1: enable_o=1, slot_o=0, format_o=1, opcode_o=0x0A, primReg_o=1, imm_o=5, secReg_o=0.
  - Cycle +2: slot_o=1, primReg_o=2, imm_o=10.
  - Cycle +3: enable_o=0.
- Bundle {0_0_0000010_00001_00010_00000000000, 30'b0}:
  - One issue: format_o=0, opcode_o=2, primReg_o=1, secReg_o=2, imm_o=0.
  - Slot1 skipped; FIFO empty next cycle.
- Continuous enable_i every cycle with DEPTH=4:
  - stall_o rises once occupancy reaches 3.
  - Fetch honouring stall_o never produces overflow.
  - Ignoring stall_o for 3 extra bundles sets overflow_o=1 and drops them.
- stall_i held high 5 cycles mid-bundle:
  - All issue outputs frozen, slot_o unchanged.
  - On release, issue resumes at slot1 with no instruction lost or repeated.
- flush_i asserted while 3 bundles are queued and enable_i=1 in the same cycle:
  - Next cycle enable_o=0, stall_o=0, FIFO empty, flush-cycle bundle not stored.
  - The next bundle issues after 1 cycle.
- reset_i driven low mid-bundle with a full FIFO and overflow_o=1:
  - All outputs 0 after that edge, overflow_o cleared, slot index 0.
